// File: rtl/rf_pkg.sv
// Shared register-file parameters for the writeback scheduler.
// Address/data widths and the hard-wired zero register index.
package rf_pkg;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NREGS = 1 << AW;
    localparam logic [AW-1:0] X0 = '0;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Grant is one-hot; the pointer moves only when a beat is granted.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LW-1:0] last;
    logic [LW-1:0] gnt_idx;
    logic [LW-1:0] idx;
    logic          found;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant   = '0;
        gnt_idx = last;
        idx     = '0;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = LW'((int'(last) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
        if (!reset_n) begin
            grant = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= LW'(NREQ - 1);
        end else if (found) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: arbitrates requesters onto the single register
// file write port and keeps a busy scoreboard for RAW/WAW stalls.
module regfile_wb_scheduler
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = rf_pkg::DW,
    parameter int AW   = rf_pkg::AW
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_rd,
    output logic               iss_ready,
    input  logic [AW-1:0]      rs1,
    input  logic [AW-1:0]      rs2,
    output logic               rs1_busy,
    output logic               rs2_busy,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_rd,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               reg_write,
    output logic [AW-1:0]      dest_reg,
    output logic [DW-1:0]      write_data
);

    localparam int NR = 1 << AW;
    localparam logic [AW-1:0] ZR = AW'(X0);

    logic [NR-1:0]   busy;
    logic [NR-1:0]   busy_nxt;
    logic [NREQ-1:0] grant;
    logic            xfer;
    logic            iss_fire;
    logic [AW-1:0]   sel_rd;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    assign iss_ready = (iss_rd == ZR) || !busy[iss_rd];
    assign iss_fire  = iss_valid && iss_ready && (iss_rd != ZR);
    assign rs1_busy  = (rs1 != ZR) && busy[rs1];
    assign rs2_busy  = (rs2 != ZR) && busy[rs2];

    // A register in its write cycle is still busy, so a same-register
    // issue is refused and can never collide with the clear.
    always_comb begin
        busy_nxt = busy;
        if (reg_write) begin
            busy_nxt[dest_reg] = 1'b0;
        end
        if (iss_fire) begin
            busy_nxt[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write  <= 1'b0;
            dest_reg   <= '0;
            write_data <= '0;
        end else begin
            reg_write <= xfer && (sel_rd != ZR);
            if (xfer) begin
                dest_reg   <= sel_rd;
                write_data <= sel_data;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && reg_write) begin
            assert (busy[dest_reg])
            else $warning("writeback to idle register %0d", dest_reg);
        end
    end
`endif

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Writeback scheduler and scoreboard for the 32 x 32-bit register file. It arbitrates up to NREQ writeback requesters onto the register file's single write port using registered round-robin grant. It tracks in-flight destination registers in a busy scoreboard, so issue logic can stall on RAW and WAW hazards. It sits between the execution/load units and the register file write inputs (`reg_write`, `dest_reg`, `write_data`).

## Interface
- `NREQ`, 2: number of writeback requesters (2..4).
- `DW`, 32: data width.
- `AW`, 5: register address width; register count is 2^AW.

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `iss_valid`  in  1  issue logic requests to mark `iss_rd` pending.
- `iss_rd`  in  AW  destination register of the issuing instruction.
- `iss_ready`  out  1  issue accepted this cycle; equals `!busy[iss_rd]`, forced 1 when `iss_rd` = 0.
- `rs1`, `rs2`  in  AW  source registers of the instruction in decode.
- `rs1_busy`, `rs2_busy`  out  1  combinational `busy[rsN]`; always 0 for x0.
- `req_valid`  in  NREQ  per-requester writeback valid.
- `req_rd`  in  NREQ*AW  packed destination registers, requester i at `[i*AW +: AW]`.
- `req_data`  in  NREQ*DW  packed write data.
- `req_ready`  out  NREQ  one-hot grant; a requester's beat transfers when its valid and ready are both 1.
- `reg_write`  out  1  register file write enable (registered).
- `dest_reg`  out  AW  register file write address (registered).
- `write_data`  out  DW  register file write data (registered).

## Operation
**Scoreboard**
- `busy` is a 2^AW-bit register.
- An issue handshake (`iss_valid && iss_ready`) with `iss_rd` != 0 sets `busy[iss_rd]`.
- Issue to an already busy register is refused (`iss_ready`=0). This is the WAW stall; at most one write per register is in flight.

**Arbitration**
- Round-robin pointer `last` holds the index of the last granted requester.
- Priority search starts at `last+1` mod NREQ.
- `req_ready` is the one-hot of the first valid requester, or all-zero when none is valid.
- The pointer updates only on a transfer.
- The output stage is always free, so one beat transfers per cycle whenever any requester is valid.

**Write stage**
- On a transfer, the output registers load `reg_write`=1, `dest_reg`=rd, `write_data`=data.
- With no transfer, `reg_write` loads 0 and `dest_reg`/`write_data` hold their values.
- A transfer with rd = 0 is accepted and consumed, but `reg_write` loads 0. x0 is never written.

**Busy clear**
- `busy[dest_reg]` clears at the clock edge that ends the cycle in which `reg_write`=1. From then on, register file reads return the new value.
- A write to a non-busy register still writes the register file. The clear is a no-op and is flagged by a simulation-only assertion.

**Simultaneous events**
- Issue to register r while r is being cleared: refused this cycle, accepted the next cycle.
- Clear of r and issue to a different register s at the same edge: both take effect.

## Timing
Reset values (`reset_n` low, asynchronous):
- `busy` = 0, `last` = NREQ-1 (requester 0 has first priority).
- `reg_write` = 0, `dest_reg` = 0, `write_data` = 0.
- `req_ready` = 0 while in reset.

Cycle-level behaviour:
- Write latency: request accepted at edge E, register file write presented in cycle E..E+1, `busy` clear visible after edge E+1.
- Throughput: one write per cycle.
- `rsN_busy`, `iss_ready` and `req_ready` are combinational from registered state and current inputs. There is no combinational path from `req_valid` to `iss_ready`.

Reset mid-operation:
- In-flight writes are dropped, the scoreboard is cleared, and `reg_write` deasserts immediately.

## Structure
- The shared package `rf_pkg` holds `AW`, `DW`, the register count localparam and the x0 index constant.
- Sub-module `rr_arbiter` (parameter NREQ) holds the pointer register and the one-hot grant logic.
- The top module holds the scoreboard and the write-stage registers.

## Test plan
1. **Reset:** assert `reset_n`=0 mid-stream → `reg_write`=0, `dest_reg`=0, `write_data`=0, `rs1_busy`=0 for all `rs1` values, `busy`=0.
2. **Issue then writeback:** issue rd=5; `rs1`=5 → `rs1_busy`=1. Requester 1 writes rd=5, data 0xDEADBEEF → one cycle later `reg_write`=1, `dest_reg`=5, `write_data`=0xDEADBEEF; `rs1_busy`=0 on the following cycle.
3. **WAW stall:** rd=7 busy, `iss_valid` with `iss_rd`=7 → `iss_ready`=0 until the cycle after register 7's write cycle, then 1.
4. **Round-robin fairness:** both requesters hold `req_valid`=1 for 6 cycles with rd=1 (requester 0) and rd=2 (requester 1) → grants alternate 0,1,0,1,0,1 and `dest_reg` sequence is 1,2,1,2,1,2.
5. **x0 write:** requester 0 writes rd=0, data 0x55 → `req_ready[0]`=1, `reg_write` stays 0, `rs2_busy` stays 0 for `rs2`=0.
6. **Simultaneous issue and clear:** register 3 is in its write cycle while issue targets rd=4 → at the next edge `busy[3]`=0 and `busy[4]`=1.
